lc3_datapath: RTL and testbench

LC-3b execution datapath core: an 8-entry x 16-bit general register file with two combinational read ports and one clocked write port, feeding a 4-function combinational ALU. Sits between the control FSM (which drives register selects, ALU op and load enables) and the processor bus (which supplies write-back data). Register file and ALU are also visible as separate outputs for bus gating by the parent.

---
 rtl/lc3_pkg.sv | 21 ++
 rtl/lc3_alu.sv | 24 ++
 rtl/lc3_datapath.sv | 85 ++++++++
 tb/tb_lc3_datapath.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3b datapath definitions: word width, register index type,
// ALU function encoding and the imm5 sign-extension helper.
package lc3_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 3;

   typedef logic [REG_AW-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      ALUK_ADD   = 2'b00,
      ALUK_AND   = 2'b01,
      ALUK_XOR   = 2'b10,
      ALUK_PASSA = 2'b11
   } aluk_e;

   function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
      return {{(DATA_W-5){v[4]}}, v};
   endfunction

endpackage

// File: rtl/lc3_alu.sv
// LC-3b combinational ALU: ADD, AND, XOR, PASSA.
// No flags are produced here; condition codes come from the bus.
module lc3_alu
   import lc3_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  aluk_e             aluk,
   output logic [DATA_W-1:0] out
);

   // Select the result of the requested function; add wraps modulo 2^16
   always_comb begin
      out = '0;
      unique case (aluk)
         ALUK_ADD:   out = a + b;
         ALUK_AND:   out = a & b;
         ALUK_XOR:   out = a ^ b;
         ALUK_PASSA: out = a;
         default:    out = '0;
      endcase
   end

endmodule

// File: rtl/lc3_datapath.sv
// LC-3b execution datapath: 8x16 register file, operand mux, ALU.
// Define LC3_DP_CC_EN to build the NZP condition-code register.
module lc3_datapath
   import lc3_pkg::*;
#(
   parameter int NREGS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              ld_reg,
   input  reg_idx_t          dr,
   input  reg_idx_t          sr1,
   input  reg_idx_t          sr2,
   input  logic              sr2mux_sel,
   input  logic [4:0]        imm5,
   input  logic [1:0]        aluk,
   input  logic              ld_cc,
   output logic [DATA_W-1:0] sr1_out,
   output logic [DATA_W-1:0] sr2_out,
   output logic [DATA_W-1:0] alu_out,
   output logic [2:0]        nzp
);

   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] alu_b;

   // Register file write port; reset clears every register at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (ld_reg) begin
         regs[dr] <= bus_in;
      end
   end

   // Read ports have no write bypass: old data until the edge
   always_comb begin
      sr1_out = regs[sr1];
      sr2_out = regs[sr2];
   end

   // Operand B is either the second register or the sign-extended imm5
   always_comb begin
      alu_b = sr2mux_sel ? sext5(imm5) : sr2_out;
   end

   lc3_alu u_alu (
      .a    (sr1_out),
      .b    (alu_b),
      .aluk (aluk_e'(aluk)),
      .out  (alu_out)
   );

`ifdef LC3_DP_CC_EN
   logic [2:0] nzp_next;

   // Classify the bus word; exactly one of N, Z, P is set
   always_comb begin
      nzp_next = 3'b001;
      if (bus_in[DATA_W-1]) begin
         nzp_next = 3'b100;
      end else if (bus_in == '0) begin
         nzp_next = 3'b010;
      end
   end

   // Condition-code register, loaded independently of the register file
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nzp <= 3'b000;
      end else if (ld_cc) begin
         nzp <= nzp_next;
      end
   end
`else
   logic unused_ld_cc;

   assign unused_ld_cc = ld_cc;
   assign nzp          = 3'b000;
`endif

endmodule

// File: tb/tb_lc3_datapath.sv
// Directed self-checking bench for lc3_datapath.
// Expected values are hand-computed constants.
module tb_lc3_datapath;
   import lc3_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [15:0] bus_in;
   logic        ld_reg;
   logic [2:0]  dr;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic        sr2mux_sel;
   logic [4:0]  imm5;
   logic [1:0]  aluk;
   logic        ld_cc;
   logic [15:0] sr1_out;
   logic [15:0] sr2_out;
   logic [15:0] alu_out;
   logic [2:0]  nzp;

   int passed = 0;
   int total  = 0;

   lc3_datapath dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus_in     (bus_in),
      .ld_reg     (ld_reg),
      .dr         (dr),
      .sr1        (sr1),
      .sr2        (sr2),
      .sr2mux_sel (sr2mux_sel),
      .imm5       (imm5),
      .aluk       (aluk),
      .ld_cc      (ld_cc),
      .sr1_out    (sr1_out),
      .sr2_out    (sr2_out),
      .alu_out    (alu_out),
      .nzp        (nzp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic wr(input logic [2:0] d, input logic [15:0] v);
      @(negedge clk);
      dr     = d;
      bus_in = v;
      ld_reg = 1'b1;
      @(posedge clk);
      #1;
      ld_reg = 1'b0;
   endtask

   task automatic cc_load(input logic [15:0] v);
      @(negedge clk);
      bus_in = v;
      ld_cc  = 1'b1;
      @(posedge clk);
      #1;
      ld_cc = 1'b0;
   endtask

   logic [15:0] a_vals [3];
   logic [15:0] exp_tab [3][4];
   logic [2:0]  a_regs [3];
   logic [2:0]  cc_exp;

   initial begin
      a_regs = '{3'd1, 3'd2, 3'd4};
      a_vals = '{16'h0001, 16'h0002, 16'h1000};
      exp_tab = '{
         '{16'h0002, 16'h0001, 16'h0000, 16'h0001},
         '{16'h0003, 16'h0000, 16'h0003, 16'h0002},
         '{16'h1001, 16'h0000, 16'h1001, 16'h1000}
      };

      rst_n      = 1'b0;
      bus_in     = '0;
      ld_reg     = 1'b0;
      dr         = '0;
      sr1        = '0;
      sr2        = '0;
      sr2mux_sel = 1'b0;
      imm5       = '0;
      aluk       = 2'b00;
      ld_cc      = 1'b0;

      #2;
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i);
         #1;
         chk($sformatf("rst_r%0d", i), sr1_out, 16'h0000);
      end
      chk("rst_nzp", {13'd0, nzp}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // single write, others stay zero
      wr(3'd3, 16'h0069);
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i);
         #1;
         chk($sformatf("wr_r%0d", i), sr1_out,
             (i == 3) ? 16'h0069 : 16'h0000);
      end

      // ALU sweep with B from register R1 = 1
      wr(3'd1, 16'h0001);
      wr(3'd2, 16'h0002);
      wr(3'd4, 16'h1000);
      sr2 = 3'd1;
      sr2mux_sel = 1'b0;
      for (int r = 0; r < 3; r++) begin
         sr1 = a_regs[r];
         for (int k = 0; k < 4; k++) begin
            aluk = 2'(k);
            #1;
            chk($sformatf("alu_a%h_k%0d", a_vals[r], k),
                alu_out, exp_tab[r][k]);
         end
      end

      // immediate operand and wrap-around
      wr(3'd1, 16'h0005);
      sr1 = 3'd1;
      sr2mux_sel = 1'b1;
      imm5 = 5'b11111;
      aluk = 2'b00;
      #1;
      chk("imm_add_m1", alu_out, 16'h0004);
      wr(3'd1, 16'hFFFF);
      imm5 = 5'b00001;
      #1;
      chk("imm_wrap", alu_out, 16'h0000);
      imm5 = 5'b10000;
      aluk = 2'b01;
      #1;
      chk("imm_and_sext", alu_out, 16'hFFF0);
      aluk = 2'b11;
      #1;
      chk("passa_ignores_b", alu_out, 16'hFFFF);
      sr2mux_sel = 1'b0;

      // no write bypass
      wr(3'd2, 16'h1234);
      @(negedge clk);
      sr1    = 3'd2;
      dr     = 3'd2;
      bus_in = 16'hBEEF;
      ld_reg = 1'b1;
      #1;
      chk("nobyp_before", sr1_out, 16'h1234);
      @(posedge clk);
      #1;
      ld_reg = 1'b0;
      chk("nobyp_after", sr1_out, 16'hBEEF);

      // same register on both ports
      sr2 = 3'd2;
      #1;
      chk("same_sr2", sr2_out, 16'hBEEF);

      // ld_reg low leaves register untouched
      @(negedge clk);
      dr     = 3'd2;
      bus_in = 16'h0000;
      @(posedge clk);
      #1;
      chk("ld_reg_off", sr1_out, 16'hBEEF);

      // condition codes
`ifdef LC3_DP_CC_EN
      cc_exp = 3'b100;
`else
      cc_exp = 3'b000;
`endif
      cc_load(16'h8000);
      chk("cc_neg", {13'd0, nzp}, {13'd0, cc_exp});
`ifdef LC3_DP_CC_EN
      cc_exp = 3'b010;
`endif
      cc_load(16'h0000);
      chk("cc_zero", {13'd0, nzp}, {13'd0, cc_exp});
`ifdef LC3_DP_CC_EN
      cc_exp = 3'b001;
`endif
      cc_load(16'h0001);
      chk("cc_pos", {13'd0, nzp}, {13'd0, cc_exp});
      sr1 = 3'd2;
      #1;
      chk("cc_no_reg_write", sr1_out, 16'hBEEF);

      // fill all registers, then asynchronous reset mid-cycle
      for (int i = 0; i < 8; i++) begin
         wr(3'(i), 16'hA000 + 16'(i * 16'h0111));
      end
      sr1 = 3'd7;
      sr2 = 3'd0;
      #1;
      chk("fill_r7", sr1_out, 16'hA777);
      chk("fill_r0", sr2_out, 16'hA000);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i);
         #1;
         chk($sformatf("arst_r%0d", i), sr1_out, 16'h0000);
      end
      chk("arst_nzp", {13'd0, nzp}, 16'h0000);
      sr1  = 3'd5;
      aluk = 2'b11;
      #1;
      chk("arst_alu", alu_out, 16'h0000);

      // writes ignored while in reset
      @(negedge clk);
      dr     = 3'd7;
      bus_in = 16'hAAAA;
      ld_reg = 1'b1;
      ld_cc  = 1'b1;
      @(posedge clk);
      #1;
      sr1 = 3'd7;
      #1;
      chk("rst_wr_blocked", sr1_out, 16'h0000);
      chk("rst_cc_blocked", {13'd0, nzp}, 16'h0000);
      @(negedge clk);
      ld_reg = 1'b0;
      ld_cc  = 1'b0;
      rst_n  = 1'b1;
      #1;
      chk("post_rst_r7", sr1_out, 16'h0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
